// File: rtl/add_err_monitor_pkg.sv
// Shared definitions for the approximate-adder error monitor.
package add_err_monitor_pkg;

    // Window control states
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam int unsigned DefBwop = 32;

    // Counter width able to hold the full sample count N = 2^log2n
    function automatic int unsigned cnt_width(input int unsigned log2n);
        return log2n + 1;
    endfunction

endpackage

// File: rtl/add_err_dist.sv
// Aligns adder operands with the registered adder result and produces the
// registered absolute error distance plus its valid flag.
module add_err_dist
    import add_err_monitor_pkg::*;
#(
    parameter int unsigned BWOP = DefBwop
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic [BWOP-1:0] a_i,
    input  logic [BWOP-1:0] b_i,
    input  logic [BWOP-1:0] c_apx_i,
    output logic            valid_o,
    output logic [BWOP-1:0] ed_o
);

    logic [BWOP-1:0] a1_q, b1_q;
    logic            v1_q;
    logic [BWOP-1:0] ed2_q, ed2_d;
    logic            v2_q;
    logic [BWOP-1:0] ex;

    // Exact modulo sum and absolute distance to the approximate result
    always_comb begin
        ex    = a1_q + b1_q;
        ed2_d = (ex >= c_apx_i) ? (ex - c_apx_i) : (c_apx_i - ex);
    end

    // Operand alignment stage, then distance register; both run in every state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a1_q  <= '0;
            b1_q  <= '0;
            v1_q  <= 1'b0;
            ed2_q <= '0;
            v2_q  <= 1'b0;
        end else begin
            a1_q  <= a_i;
            b1_q  <= b_i;
            v1_q  <= valid_i;
            ed2_q <= ed2_d;
            v2_q  <= v1_q;
        end
    end

    assign valid_o = v2_q;
    assign ed_o    = ed2_q;

endmodule

// File: rtl/add_err_monitor.sv
// Error-statistics monitor for a registered approximate adder: collects
// error count, max, sum and mean distance over a window of 2^LOG2N samples.
module add_err_monitor
    import add_err_monitor_pkg::*;
#(
    parameter int unsigned BWOP  = DefBwop,
    parameter int unsigned LOG2N = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_i,
    input  logic                          in_valid_i,
    input  logic [BWOP-1:0]               a_i,
    input  logic [BWOP-1:0]               b_i,
    input  logic [BWOP-1:0]               c_apx_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic [cnt_width(LOG2N)-1:0]   err_cnt_o,
    output logic [BWOP-1:0]               max_ed_o,
    output logic [BWOP+LOG2N-1:0]         sum_ed_o,
    output logic [BWOP-1:0]               mean_ed_o
);

    localparam int unsigned CntW = cnt_width(LOG2N);
    localparam int unsigned N    = 1 << LOG2N;
    localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [CntW-1:0]        err_cnt_q, err_cnt_d;
    logic [BWOP-1:0]        max_ed_q, max_ed_d;
    logic [BWOP+LOG2N-1:0]  sum_ed_q, sum_ed_d;
    logic                   v2;
    logic [BWOP-1:0]        ed2;
    logic                   accept;

    add_err_dist #(
        .BWOP (BWOP)
    ) u_dist (
        .clk     (clk),
        .rst     (rst),
        .valid_i (in_valid_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .c_apx_i (c_apx_i),
        .valid_o (v2),
        .ed_o    (ed2)
    );

    assign accept = v2 && (state_q == StRun);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= StIdle;
        else      state_q <= state_d;
    end

    // Next-state: finish on the edge that accepts the last sample of the window
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start_i) state_d = StRun;
            StRun:  if (accept && (cnt_q == LastCnt)) state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        busy_o = (state_q == StRun);
        done_o = (state_q == StDone);
    end

    // Accumulator next-state: clear on accepted start, update on accepted sample
    always_comb begin
        cnt_d     = cnt_q;
        err_cnt_d = err_cnt_q;
        max_ed_d  = max_ed_q;
        sum_ed_d  = sum_ed_q;
        if (state_q == StIdle && start_i) begin
            cnt_d     = '0;
            err_cnt_d = '0;
            max_ed_d  = '0;
            sum_ed_d  = '0;
        end else if (accept) begin
            cnt_d     = cnt_q + 1'b1;
            err_cnt_d = err_cnt_q + CntW'(ed2 != '0);
            if (ed2 > max_ed_q) max_ed_d = ed2;
            sum_ed_d  = sum_ed_q + {{LOG2N{1'b0}}, ed2};
        end
    end

    // Accumulator registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            err_cnt_q <= '0;
            max_ed_q  <= '0;
            sum_ed_q  <= '0;
        end else begin
            cnt_q     <= cnt_d;
            err_cnt_q <= err_cnt_d;
            max_ed_q  <= max_ed_d;
            sum_ed_q  <= sum_ed_d;
        end
    end

    assign err_cnt_o = err_cnt_q;
    assign max_ed_o  = max_ed_q;
    assign sum_ed_o  = sum_ed_q;
    assign mean_ed_o = sum_ed_q[BWOP+LOG2N-1:LOG2N];

endmodule

// File: tb/tb_add_err_monitor.sv
// Bench for add_err_monitor: two instances (N=4 and N=16) share one stimulus
// stream and are compared every cycle against a window-level model.
module tb_add_err_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, in_valid;
    logic [7:0] a, b, c_apx;

    logic        busy0, done0, busy1, done1;
    logic [2:0]  err0;
    logic [4:0]  err1;
    logic [7:0]  max0, max1, mean0, mean1;
    logic [9:0]  sum0;
    logic [11:0] sum1;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    add_err_monitor #(.BWOP(8), .LOG2N(2)) dut0 (
        .clk(clk), .rst(rst), .start_i(start), .in_valid_i(in_valid),
        .a_i(a), .b_i(b), .c_apx_i(c_apx),
        .busy_o(busy0), .done_o(done0), .err_cnt_o(err0), .max_ed_o(max0),
        .sum_ed_o(sum0), .mean_ed_o(mean0)
    );

    add_err_monitor #(.BWOP(8), .LOG2N(4)) dut1 (
        .clk(clk), .rst(rst), .start_i(start), .in_valid_i(in_valid),
        .a_i(a), .b_i(b), .c_apx_i(c_apx),
        .busy_o(busy1), .done_o(done1), .err_cnt_o(err1), .max_ed_o(max1),
        .sum_ed_o(sum1), .mean_ed_o(mean1)
    );

    // Window model: state 0=idle 1=run 2=done, plus per-window statistics
    int ms[2], mcnt[2], merr[2], mmax[2], msum[2];
    int nwin[2] = '{4, 16};
    int lg[2]   = '{2, 4};
    // Each sample's distance is known one edge after it is taken and
    // becomes countable one edge later still
    int p_v1, p_a1, p_b1, p_v2, p_ed2;
    logic [7:0] pend_c;

    function automatic logic [7:0] ex8(input logic [7:0] x, input logic [7:0] y);
        return x + y;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            ms[i] = 0; mcnt[i] = 0; merr[i] = 0; mmax[i] = 0; msum[i] = 0;
        end
        p_v1 = 0; p_a1 = 0; p_b1 = 0; p_v2 = 0; p_ed2 = 0;
    endtask

    // Applies one rising edge to the model, using the inputs held across it
    task automatic model_edge();
        int ex, ed;
        if (!rst) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 2; i++) begin
            case (ms[i])
                0: if (start) begin
                    ms[i] = 1; mcnt[i] = 0; merr[i] = 0; mmax[i] = 0; msum[i] = 0;
                end
                1: if (p_v2 != 0) begin
                    mcnt[i]++;
                    msum[i] += p_ed2;
                    if (p_ed2 != 0) merr[i]++;
                    if (p_ed2 > mmax[i]) mmax[i] = p_ed2;
                    if (mcnt[i] == nwin[i]) ms[i] = 2;
                end
                default: ms[i] = 0;
            endcase
        end
        ex = (p_a1 + p_b1) % 256;
        ed = (ex >= int'(c_apx)) ? ex - int'(c_apx) : int'(c_apx) - ex;
        p_v2 = p_v1; p_ed2 = ed;
        p_v1 = in_valid; p_a1 = a; p_b1 = b;
    endtask

    task automatic check_all();
        chk("busy0", busy0, ms[0] == 1);
        chk("done0", done0, ms[0] == 2);
        chk("err_cnt0", err0, merr[0]);
        chk("max_ed0", max0, mmax[0]);
        chk("sum_ed0", sum0, msum[0]);
        chk("mean_ed0", mean0, msum[0] >> lg[0]);
        chk("busy1", busy1, ms[1] == 1);
        chk("done1", done1, ms[1] == 2);
        chk("err_cnt1", err1, merr[1]);
        chk("max_ed1", max1, mmax[1]);
        chk("sum_ed1", sum1, msum[1]);
        chk("mean_ed1", mean1, msum[1] >> lg[1]);
    endtask

    // One clock: drive at negedge, update model after posedge, compare at negedge.
    // cn is the adder result that will appear next cycle for this a/b pair.
    task automatic cyc(input logic st, input logic v, input logic [7:0] aa,
                       input logic [7:0] bb, input logic [7:0] cn);
        start = st; in_valid = v; a = aa; b = bb;
        c_apx = pend_c;
        pend_c = cn;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    endtask

    task automatic wait_done(input int idx, input int bound);
        bit seen = 0;
        for (int i = 0; i < bound && !seen; i++) begin
            if ((idx == 0 && done0) || (idx == 1 && done1)) seen = 1;
            else idle(1);
        end
        if (!seen) begin
            tests++; failed++;
            $display("FAIL wait_done%0d: got no done expected done within %0d cycles", idx, bound);
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        model_reset();
        #1;
        idle(2);
        rst = 1'b1;
        idle(1);
    endtask

    logic [7:0] ta[4] = '{8'd10, 8'd255, 8'd0, 8'd100};
    logic [7:0] tb[4] = '{8'd20, 8'd1, 8'd0, 8'd27};
    logic [7:0] inj[4] = '{8'd3, 8'd0, 8'd5, 8'd0};
    logic [7:0] ra, rb, rc;
    bit [6:0] pat = 7'b1011001; // in_valid 1,0,0,1,1,0,1 read from bit 0 upward

    initial begin
        rst = 1'b0; start = 0; in_valid = 0; a = 0; b = 0; c_apx = 0; pend_c = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_err", err0, 0);
        chk("rst_max", max0, 0);
        chk("rst_sum", sum0, 0);
        chk("rst_sum1", sum1, 0);
        rst = 1'b1;
        idle(2);

        // 1: exact adder
        cyc(1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, ta[i], tb[i], ex8(ta[i], tb[i]));
        wait_done(0, 10);
        chk("t1_done", done0, 1);
        chk("t1_err", err0, 0);
        chk("t1_sum", sum0, 0);
        chk("t1_max", max0, 0);
        chk("t1_mean", mean0, 0);
        idle(2);

        // 2: injected errors {3,0,5,0}
        cyc(1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, ta[i], tb[i], ex8(ta[i], tb[i]) + inj[i]);
        wait_done(0, 10);
        chk("t2_err", err0, 2);
        chk("t2_max", max0, 5);
        chk("t2_sum", sum0, 8);
        chk("t2_mean", mean0, 2);
        chk("t2_model_sum", msum[0], 8);
        idle(3);

        // 3: wrap-around and both signs of the distance
        cyc(1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
        cyc(1'b0, 1'b1, 8'd200, 8'd100, 8'd250);
        cyc(1'b0, 1'b1, 8'd200, 8'd100, 8'd0);
        cyc(1'b0, 1'b1, 8'd1, 8'd1, 8'd2);
        cyc(1'b0, 1'b1, 8'd1, 8'd1, 8'd2);
        wait_done(0, 10);
        chk("t3_max", max0, 206);
        chk("t3_sum", sum0, 250);
        chk("t3_err", err0, 2);
        chk("t3_mean", mean0, 62);
        chk("t3_model_max", mmax[0], 206);
        idle(2);

        // 4: bubbles, start pulses during RUN, done latency
        cyc(1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
        for (int i = 0; i < 7; i++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            cyc(!pat[i], pat[i], ra, rb, ex8(ra, rb) + 8'd1);
        end
        chk("t4_lat_k", done0, 0);
        idle(1);
        chk("t4_lat_k1", done0, 0);
        idle(1);
        chk("t4_lat_k2", done0, 1);
        chk("t4_err", err0, 4);
        chk("t4_sum", sum0, 4);
        chk("t4_mean", mean0, 1);
        idle(2);
        chk("t4_hold_sum", sum0, 4);

        // 5: reset mid-window aborts, then a clean window
        pulse_reset();
        cyc(1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
        cyc(1'b0, 1'b1, 8'd5, 8'd6, 8'd20);
        cyc(1'b0, 1'b1, 8'd7, 8'd8, 8'd0);
        idle(2);
        chk("t5_pre_sum", sum0, 24);
        rst = 1'b0;
        model_reset();
        #1;
        chk("t5_busy", busy0, 0);
        chk("t5_sum", sum0, 0);
        chk("t5_err", err0, 0);
        chk("t5_max", max0, 0);
        idle(2);
        rst = 1'b1;
        idle(3);
        cyc(1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, ta[i], tb[i], ex8(ta[i], tb[i]) + 8'd1);
        wait_done(0, 10);
        chk("t5_err2", err0, 4);
        chk("t5_sum2", sum0, 4);

        // 6: saturation on the 16-sample instance
        pulse_reset();
        cyc(1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 8'd0, 8'd0, 8'd255);
        wait_done(1, 10);
        chk("t6_sum", sum1, 4080);
        chk("t6_err", err1, 16);
        chk("t6_mean", mean1, 255);
        chk("t6_max", max1, 255);
        chk("t6_model_sum", msum[1], 4080);
        idle(2);

        // Random traffic with occasional starts and resets
        for (int i = 0; i < 1500; i++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            case ($urandom_range(0, 2))
                0: rc = ex8(ra, rb);
                1: rc = ex8(ra, rb) + 8'($urandom_range(0, 7));
                default: rc = 8'($urandom);
            endcase
            rst = ($urandom_range(0, 399) != 0);
            cyc($urandom_range(0, 11) == 0, $urandom_range(0, 3) != 0, ra, rb, rc);
        end
        rst = 1'b1;
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
